// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max-pool with ReLU over a row-major sign-magnitude pixel stream.
// Latency: one cycle from the odd-row/odd-column pixel that closes a window to out_valid.
// Backpressure: none; the producer paces through in_valid and every output pulse must be taken.
module maxpool_2x2_stream #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  // One line-buffer entry per horizontal pair of the even row.
  localparam int LB_N = IMG_W / 2;
  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int AW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Pairwise max followed by ReLU. A set sign bit means negative, including
  // negative zero, so two negatives collapse to all-zero.
  function automatic logic [DATA_W-1:0] max_relu(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (!a[DATA_W-1] && !b[DATA_W-1]) begin
      r = (a[DATA_W-2:0] >= b[DATA_W-2:0]) ? a : b;
    end else if (!a[DATA_W-1]) begin
      r = a;
    end else if (!b[DATA_W-1]) begin
      r = b;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;

  // Line buffer: no reset needed, every entry is written in the even row
  // before the odd row of the same frame reads it.
  logic [DATA_W-1:0] lb_q [LB_N];
  logic              lb_we;
  logic [AW-1:0]     lb_addr;
  logic [DATA_W-1:0] lb_wdat;

  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;
  logic              col_odd;
  logic              row_odd;
  logic              col_last;
  logic              row_last;

  // Position decode, pooling datapath and counter/next-state update.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    col_odd  = col_q[0];
    row_odd  = row_q[0];
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);

    // Read and write share the same address: column pair index.
    lb_addr  = AW'(col_q >> 1);
    pair_max = max_relu(hold_q, in_data);
    win_max  = max_relu(lb_q[lb_addr], pair_max);
    lb_wdat  = pair_max;

    if (in_valid) begin
      if (!col_odd) begin
        // Left pixel of a pair, in either row parity.
        hold_d = in_data;
      end else if (!row_odd) begin
        // Top pair complete: park its max for the row below.
        lb_we = 1'b1;
      end else begin
        // Bottom-right pixel closes the 2x2 window.
        out_data_d   = win_max;
        out_valid_d  = 1'b1;
        frame_done_d = row_last && col_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counters, hold register and output registers; all cleared by reset so a
  // partial frame is abandoned cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-buffer write port.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_addr] <= lb_wdat;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream on a 4x4 frame with a queue scoreboard.
// Stimulus pushes expected outputs with their due cycle; a monitor pops and compares.
// The DUT has no backpressure, so the monitor accepts every pulse.
module tb_maxpool_2x2_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 18;
  localparam logic [DW-1:0] NEG = 18'h20000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;

  maxpool_2x2_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [DW-1:0] dat;
    logic          fd;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int out_cnt = 0;
  logic [DW-1:0] prev_dat;

  logic [DW-1:0] frames [3][16];
  logic [DW-1:0] exp_v  [3][4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dat = '0;
    end else if (out_valid) begin
      out_cnt++;
      if (frame_done) fd_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", int'(out_data), int'(e.dat));
        chk("frame_done", int'(frame_done), int'(e.fd));
        chk("out_latency_cycle", cyc, e.cyc);
      end
      prev_dat = out_data;
    end else begin
      chk("idle_frame_done", int'(frame_done), 0);
      chk("idle_out_data_hold", int'(out_data), int'(prev_dat));
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_output", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
  endtask

  // Send pixels first..last of frame f; optional random 0-3 cycle gaps.
  task automatic send_pixels(input int f, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = frames[f][i];
      if (((i % W) % 2 == 1) && ((i / W) % 2 == 1)) begin
        exp_t e;
        e.dat = exp_v[f][(i / (2 * W)) * 2 + (i % W) / 2];
        e.fd  = (i == W * H - 1);
        e.cyc = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    int fd0;
    int oc0;

    // Frame 0: positives 0..15 -> 5, 7, 13, 15.
    for (int i = 0; i < 16; i++) frames[0][i] = DW'(i);
    exp_v[0][0] = 18'd5;  exp_v[0][1] = 18'd7;
    exp_v[0][2] = 18'd13; exp_v[0][3] = 18'd15;
    // Frame 1: negatives with magnitudes 1..16 -> all zero.
    for (int i = 0; i < 16; i++) frames[1][i] = NEG | DW'(i + 1);
    for (int i = 0; i < 4; i++) exp_v[1][i] = '0;
    // Frame 2: mixed-sign windows, including negative zero.
    //   row0: -9  +3  -0  -0
    //   row1: -0  +3  -0  -0
    //   row2: +4 -20  +9  +1
    //   row3: +2  +6 -100 +8
    frames[2][0]  = NEG | 18'd9;   frames[2][1]  = 18'd3;
    frames[2][2]  = NEG;           frames[2][3]  = NEG;
    frames[2][4]  = NEG;           frames[2][5]  = 18'd3;
    frames[2][6]  = NEG;           frames[2][7]  = NEG;
    frames[2][8]  = 18'd4;         frames[2][9]  = NEG | 18'd20;
    frames[2][10] = 18'd9;         frames[2][11] = 18'd1;
    frames[2][12] = 18'd2;         frames[2][13] = 18'd6;
    frames[2][14] = NEG | 18'd100; frames[2][15] = 18'd8;
    exp_v[2][0] = 18'd3; exp_v[2][1] = 18'd0;
    exp_v[2][2] = 18'd6; exp_v[2][3] = 18'd9;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #3 rst_n = 1'b0;
    #2 check_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk) rst_n = 1'b1;

    send_pixels(0, 0, 15, 1'b0);
    idle(3);
    send_pixels(1, 0, 15, 1'b0);
    idle(3);
    send_pixels(2, 0, 15, 1'b0);
    idle(3);
    send_pixels(0, 0, 15, 1'b1);
    idle(3);

    // Mid-frame reset after 6 pixels, then a fresh frame.
    send_pixels(0, 0, 5, 1'b0);
    idle(3);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset_assert");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("midreset_held");
    @(negedge clk) rst_n = 1'b1;
    oc0 = out_cnt;
    send_pixels(2, 0, 15, 1'b0);
    idle(3);
    chk("post_reset_output_count", out_cnt - oc0, 4);

    // Two frames back to back.
    fd0 = fd_cnt;
    oc0 = out_cnt;
    send_pixels(0, 0, 15, 1'b0);
    send_pixels(1, 0, 15, 1'b0);
    idle(4);
    chk("b2b_output_count", out_cnt - oc0, 8);
    chk("b2b_frame_done_count", fd_cnt - fd0, 2);

    idle(6);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
